// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants: data/address widths, register count and
// register index names used by the decoder, writeback mux and register file.
package cpu_pkg;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 3;
  localparam int REG_COUNT = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] R0 = 3'd0;
  localparam logic [ADDR_W-1:0] R1 = 3'd1;
  localparam logic [ADDR_W-1:0] R2 = 3'd2;
  localparam logic [ADDR_W-1:0] R3 = 3'd3;
  localparam logic [ADDR_W-1:0] R4 = 3'd4;
  localparam logic [ADDR_W-1:0] R5 = 3'd5;
  localparam logic [ADDR_W-1:0] R6 = 3'd6;
  localparam logic [ADDR_W-1:0] R7 = 3'd7;

endpackage

// File: rtl/reg_read_port.sv
// One combinational register-file read port with write-through bypass and
// optional hard-wired zero register.
module reg_read_port
  import cpu_pkg::*;
#(
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int ADDR_W   = cpu_pkg::ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] stored,
  input  logic              wr_commit,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam bit ZERO_EN = (ZERO_REG != 0);

  // Zero register has the final say, so even a bypass aimed at r0 reads 0.
  always_comb begin
    rdata = stored;
    if (wr_commit && (raddr == waddr)) begin
      rdata = wdata;
    end
    if (ZERO_EN && (raddr == ADDR_W'(R0))) begin
      rdata = '0;
    end
  end

endmodule

// File: rtl/reg_file_16.sv
// Eight-entry 16-bit register file: two bypassed combinational read ports,
// one synchronous write port, a registered debug read port and a write counter.
module reg_file_16
  import cpu_pkg::*;
#(
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int ADDR_W   = cpu_pkg::ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [7:0]        wr_count
);

  localparam int DEPTH   = 2 ** ADDR_W;
  localparam bit ZERO_EN = (ZERO_REG != 0);

  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr_commit;

  // A write counts only outside reset and when it is not a dropped r0 write.
  assign wr_commit = rst_n && we && !(ZERO_EN && (waddr == ADDR_W'(R0)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      dbg_data <= '0;
      wr_count <= '0;
    end else begin
      if (wr_commit) begin
        regs[waddr] <= wdata;
        if (wr_count != 8'hFF) begin
          wr_count <= wr_count + 8'd1;
        end
      end
      dbg_data <= regs[dbg_addr];
    end
  end

  reg_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_port_a (
    .raddr    (raddr_a),
    .stored   (regs[raddr_a]),
    .wr_commit(wr_commit),
    .waddr    (waddr),
    .wdata    (wdata),
    .rdata    (rdata_a)
  );

  reg_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_port_b (
    .raddr    (raddr_b),
    .stored   (regs[raddr_b]),
    .wr_commit(wr_commit),
    .waddr    (waddr),
    .wdata    (wdata),
    .rdata    (rdata_b)
  );

endmodule
